fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one memory read per Start, loads IR and the
// next PC, applies branch/jump redirects, and flags (sticky) fetch timeouts.
module fetch_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int PC_INC  = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Redirect,
  input  logic [15:0] RedirectAddr,
  input  logic [15:0] PCIn,
  input  logic [15:0] MemRdata,
  input  logic        MemReady,
  output logic [15:0] MemAddr,
  output logic        MemRead,
  output logic [15:0] PCNext,
  output logic        PCWrite,
  output logic [15:0] IR,
  output logic        IRValid,
  output logic        Busy,
  output logic        Fault
);

  localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0]   INC      = 16'(PC_INC);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_UPDATE = 2'd2,
    S_REDIR  = 2'd3
  } state_t;

  state_t          state_q;
  logic [15:0]     mem_addr_q;
  logic            mem_read_q;
  logic [15:0]     pc_next_q;
  logic            pc_write_q;
  logic [15:0]     ir_q;
  logic            ir_valid_q;
  logic            fault_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [15:0]     pc_inc_d;

  // Sequential address wraps modulo 2^16 by construction of the 16-bit add.
  assign pc_inc_d = mem_addr_q + INC;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      pc_next_q  <= '0;
      pc_write_q <= 1'b0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      pc_write_q <= 1'b0;
      ir_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Redirect) begin
            pc_next_q  <= RedirectAddr;
            pc_write_q <= 1'b1;
            state_q    <= S_REDIR;
          end else if (Start) begin
            mem_addr_q <= PCIn;
            wait_cnt_q <= '0;
            mem_read_q <= 1'b1;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Ready is tested before the timeout so a last-cycle response still succeeds.
          if (MemReady) begin
            ir_q       <= MemRdata;
            pc_next_q  <= pc_inc_d;
            mem_read_q <= 1'b0;
            pc_write_q <= 1'b1;
            ir_valid_q <= 1'b1;
            state_q    <= S_UPDATE;
          end else if (wait_cnt_q == CNT_LAST) begin
            fault_q    <= 1'b1;
            mem_read_q <= 1'b0;
            state_q    <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_UPDATE: state_q <= S_IDLE;
        S_REDIR:  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign MemAddr = mem_addr_q;
  assign MemRead = mem_read_q;
  assign PCNext  = pc_next_q;
  assign PCWrite = pc_write_q;
  assign IR      = ir_q;
  assign IRValid = ir_valid_q;
  assign Busy    = (state_q != S_IDLE);
  assign Fault   = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: the driver pushes the outcome each fetch or
// redirect should have; a negedge monitor pops it whenever the DUT retires one.
module tb_fetch_sequencer;

  localparam int TIMEOUT = 15;
  localparam int PC_INC  = 2;
  localparam int K_FETCH = 0;
  localparam int K_REDIR = 1;
  localparam int K_TOUT  = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectAddr = '0;
  logic [15:0] PCIn = '0;
  logic [15:0] MemRdata = '0;
  logic        MemReady = 1'b0;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [15:0] PCNext;
  logic        PCWrite;
  logic [15:0] IR;
  logic        IRValid;
  logic        Busy;
  logic        Fault;

  fetch_sequencer #(.TIMEOUT(TIMEOUT), .PC_INC(PC_INC)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Redirect(Redirect),
    .RedirectAddr(RedirectAddr), .PCIn(PCIn), .MemRdata(MemRdata),
    .MemReady(MemReady), .MemAddr(MemAddr), .MemRead(MemRead),
    .PCNext(PCNext), .PCWrite(PCWrite), .IR(IR), .IRValid(IRValid),
    .Busy(Busy), .Fault(Fault)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          kind;
    logic [15:0] pcnext;
    logic [15:0] ir;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_ir = '0;
  logic [15:0] m_pcnext = '0;
  bit          m_fault = 1'b0;
  bit          prev_busy = 1'b0;
  bit          prev_pw = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a PCWrite pulse retires a fetch or redirect; Busy falling without a
  // preceding PCWrite retires a timed-out fetch.
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en) begin
      if (PCWrite) begin
        if (sbq.size() == 0) begin
          check("unexpected_pcwrite", 32'(PCWrite), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("pcwrite_expected", 32'(e.kind != K_TOUT), 32'd1);
          check("pcnext", 32'(PCNext), 32'(e.pcnext));
          check("ir", 32'(IR), 32'(e.ir));
          check("irvalid", 32'(IRValid), 32'(e.kind == K_FETCH));
          check("memread_off_on_pcwrite", 32'(MemRead), 32'd0);
          $display("retire kind=%0d pcnext=0x%04h ir=0x%04h", e.kind, PCNext, IR);
        end
      end else if (prev_busy && !Busy && !prev_pw) begin
        if (sbq.size() == 0) begin
          check("unexpected_abort", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("abort_expected", 32'(e.kind == K_TOUT), 32'd1);
          check("fault_on_timeout", 32'(Fault), 32'd1);
          check("pcnext_kept", 32'(PCNext), 32'(e.pcnext));
          check("ir_kept", 32'(IR), 32'(e.ir));
          check("memread_off_on_abort", 32'(MemRead), 32'd0);
          $display("retire timeout pcnext=0x%04h ir=0x%04h", PCNext, IR);
        end
      end
    end
    prev_busy <= Busy;
    prev_pw   <= PCWrite;
  end

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      MemReady = 1'($urandom_range(0, 1));
      MemRdata = 16'($urandom);
    end
    @(negedge CLK);
    MemReady = 1'b0;
    check("fault_sticky", 32'(Fault), 32'(m_fault));
    check("idle_not_busy", 32'(Busy), 32'd0);
  endtask

  // w = number of cycles without MemReady before the response; w >= TIMEOUT never answers.
  task automatic do_fetch(input logic [15:0] pc, input int w, input logic [15:0] data);
    bit   to;
    exp_t e;
    int   rd;
    bit   busy_ok;
    to = (w >= TIMEOUT);
    rd = 0;
    busy_ok = 1'b1;
    if (to) begin
      m_fault = 1'b1;
      e = '{K_TOUT, m_pcnext, m_ir};
    end else begin
      m_ir = data;
      m_pcnext = pc + 16'(PC_INC);
      e = '{K_FETCH, m_pcnext, m_ir};
    end
    sbq.push_back(e);
    @(negedge CLK);
    PCIn = pc;
    Start = 1'b1;
    Redirect = 1'b0;
    MemReady = 1'b0;
    @(negedge CLK);
    Start = 1'b0;
    PCIn = 16'($urandom);
    check("memaddr_latched", 32'(MemAddr), 32'(pc));
    for (int i = 0; i < TIMEOUT; i++) begin
      MemReady = (!to && i == w);
      MemRdata = MemReady ? data : 16'($urandom);
      Start = 1'($urandom_range(0, 1));
      Redirect = 1'($urandom_range(0, 1));
      RedirectAddr = 16'($urandom);
      if (MemRead) rd++;
      if (!Busy || MemAddr !== pc) busy_ok = 1'b0;
      @(negedge CLK);
      if (MemReady) break;
    end
    MemReady = 1'b0;
    Start = 1'b0;
    Redirect = 1'b0;
    check("memread_cycles", 32'(rd), to ? 32'(TIMEOUT) : 32'(w + 1));
    check("busy_addr_stable_in_wait", 32'(busy_ok), 32'd1);
    check("fault_after_wait", 32'(Fault), 32'(m_fault));
    $display("fetch pc=0x%04h waits=%0d timeout=%0d data=0x%04h", pc, w, to, data);
    if (!to) @(negedge CLK);
  endtask

  task automatic do_redirect(input logic [15:0] a, input bit also_start);
    m_pcnext = a;
    sbq.push_back('{K_REDIR, a, m_ir});
    @(negedge CLK);
    Redirect = 1'b1;
    RedirectAddr = a;
    Start = also_start;
    PCIn = 16'($urandom);
    @(negedge CLK);
    Redirect = 1'b0;
    Start = 1'b0;
    check("redir_no_memread", 32'(MemRead), 32'd0);
    check("redir_busy", 32'(Busy), 32'd1);
    @(negedge CLK);
    check("redir_single_pcwrite", 32'(PCWrite), 32'd0);
    $display("redirect addr=0x%04h with_start=%0d", a, also_start);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memaddr"}, 32'(MemAddr), 32'd0);
    check({tag, "_memread"}, 32'(MemRead), 32'd0);
    check({tag, "_pcnext"}, 32'(PCNext), 32'd0);
    check({tag, "_pcwrite"}, 32'(PCWrite), 32'd0);
    check({tag, "_ir"}, 32'(IR), 32'd0);
    check({tag, "_irvalid"}, 32'(IRValid), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_fault"}, 32'(Fault), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    repeat (2) @(negedge CLK);
    check_all_zero("reset");
    Reset = 1'b0;
    mon_en = 1'b1;

    do_fetch(16'h0040, 0, 16'hA5C3);
    idle_gap(2);
    do_fetch(16'hFFFE, 3, 16'h5A5A);
    idle_gap(1);
    do_redirect(16'h1230, 1'b1);
    idle_gap(1);
    do_fetch(16'h0100, TIMEOUT, 16'h0000);
    idle_gap(2);
    do_fetch(16'h0102, 1, 16'h1234);
    idle_gap(1);
    do_fetch(16'h0200, TIMEOUT - 1, 16'hCAFE);
    idle_gap(1);

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) do_redirect(16'($urandom), 1'($urandom_range(0, 1)));
      else if (r == 9) do_fetch(16'($urandom), TIMEOUT, 16'($urandom));
      else do_fetch(16'($urandom), $urandom_range(0, 6), 16'($urandom));
      idle_gap($urandom_range(0, 3));
    end

    @(negedge CLK);
    PCIn = 16'h2222;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    mon_en = 1'b0;
    Reset = 1'b1;
    MemReady = 1'b1;
    MemRdata = 16'hBEEF;
    @(negedge CLK);
    check_all_zero("midfetch_reset");
    Reset = 1'b0;
    MemReady = 1'b0;
    @(negedge CLK);
    check("post_reset_pcwrite", 32'(PCWrite), 32'd0);
    check("post_reset_ir", 32'(IR), 32'd0);
    $display("reset during WAIT with MemReady");
    m_ir = '0;
    m_pcnext = '0;
    m_fault = 1'b0;
    sbq.delete();
    mon_en = 1'b1;

    do_fetch(16'h3000, 2, 16'h0F0F);
    idle_gap(3);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
